// File: rtl/lane_path_ctrl_pkg.sv
// Shared types and constants for the cross-lane network sequencer.
// Selector codes: bit 4 steers a lane onto the network, bits 3:0 carry the rotation.
package lane_path_ctrl_pkg;

  typedef enum logic [1:0] {
    LPC_IDLE = 2'd0,
    LPC_SRC  = 2'd1,
    LPC_WB   = 2'd2
  } lpc_state_t;

  localparam int         SEL_LANE_BIT = 4;
  localparam logic [4:0] SEL_WB_EXEC  = 5'h00;

  function automatic logic [4:0] lane_code(input logic [3:0] rot);
    logic [4:0] code;
    code               = SEL_WB_EXEC;
    code[SEL_LANE_BIT] = 1'b1;
    code[3:0]          = rot;
    return code;
  endfunction

endpackage

// File: rtl/lane_path_ctrl_rot_seq.sv
// Beat sequencer shared by both op types: latches base/stride/len on load,
// then steps the lane rotation and beat counter on every unstalled beat.
module lane_rot_seq #(
  parameter int NUM_LANES = 16,
  parameter int LEN_W     = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic             advance,
  input  logic [3:0]       base,
  input  logic [3:0]       stride,
  input  logic [LEN_W-1:0] len,
  output logic [3:0]       rot,
  output logic             last
);

  localparam logic [3:0] ROT_MASK = 4'(NUM_LANES - 1);

  logic [3:0]       rot_r;
  logic [3:0]       stride_r;
  logic [LEN_W-1:0] len_r;
  logic [LEN_W-1:0] beat_r;

  // Operand latch and rotation/beat counters; the mask folds the wrap for narrow networks
  always_ff @(posedge clock) begin
    if (reset) begin
      rot_r    <= 4'd0;
      stride_r <= 4'd0;
      len_r    <= '0;
      beat_r   <= '0;
    end else if (load) begin
      rot_r    <= base & ROT_MASK;
      stride_r <= stride;
      len_r    <= len;
      beat_r   <= '0;
    end else if (advance) begin
      rot_r    <= (rot_r + stride_r) & ROT_MASK;
      beat_r   <= beat_r + LEN_W'(1);
    end else begin
      rot_r    <= rot_r;
      beat_r   <= beat_r;
    end
  end

  assign rot  = rot_r;
  assign last = (beat_r == len_r);

endmodule

// File: rtl/lane_path_ctrl.sv
// Arbiter and sequencer for the shared cross-lane network: grants the source or
// write-back permute requester round-robin and broadcasts the per-beat selector codes.
module lane_path_ctrl
  import lane_path_ctrl_pkg::*;
#(
  parameter int NUM_LANES = 16,
  parameter int LEN_W     = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             I_Req_Src,
  input  logic [3:0]       I_Src_Base,
  input  logic [3:0]       I_Src_Stride,
  input  logic [LEN_W-1:0] I_Src_Len,
  output logic             O_Ack_Src,
  input  logic             I_Req_WB,
  input  logic [3:0]       I_WB_Base,
  input  logic [3:0]       I_WB_Stride,
  input  logic [LEN_W-1:0] I_WB_Len,
  output logic             O_Ack_WB,
  input  logic [1:0]       I_Local_Sel,
  input  logic             I_Stall,
  output logic             O_Lane_Req,
  output logic [4:0]       O_Sel_Path,
  output logic [4:0]       O_Sel_Path_WB,
  output logic             O_Beat_Valid,
  output logic             O_Done_Src,
  output logic             O_Done_WB,
  output logic             O_Busy
);

  lpc_state_t       state_r, state_nxt_s;
  logic             rr_last_wb_r;
  logic             idle_s, running_s, advance_s;
  logic             grant_src_s, grant_wb_s, load_s;
  logic [3:0]       base_s, stride_s, rot_s;
  logic [LEN_W-1:0] len_s;
  logic             last_s;

  // Arbitration: a lone request wins; on a tie the side that did not win last time goes
  always_comb begin
    idle_s      = (state_r == LPC_IDLE) && !reset;
    running_s   = (state_r != LPC_IDLE) && !reset;
    advance_s   = running_s && !I_Stall;
    grant_src_s = idle_s && I_Req_Src && (!I_Req_WB || rr_last_wb_r);
    grant_wb_s  = idle_s && I_Req_WB && !grant_src_s;
    load_s      = grant_src_s || grant_wb_s;
    if (grant_wb_s) begin
      base_s   = I_WB_Base;
      stride_s = I_WB_Stride;
      len_s    = I_WB_Len;
    end else begin
      base_s   = I_Src_Base;
      stride_s = I_Src_Stride;
      len_s    = I_Src_Len;
    end
  end

  lane_rot_seq #(
    .NUM_LANES (NUM_LANES),
    .LEN_W     (LEN_W)
  ) u_rot_seq (
    .clock   (clock),
    .reset   (reset),
    .load    (load_s),
    .advance (advance_s),
    .base    (base_s),
    .stride  (stride_s),
    .len     (len_s),
    .rot     (rot_s),
    .last    (last_s)
  );

  // Next-state: an op leaves its run state only on its final unstalled beat
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      LPC_IDLE: begin
        if (grant_src_s) begin
          state_nxt_s = LPC_SRC;
        end else if (grant_wb_s) begin
          state_nxt_s = LPC_WB;
        end else begin
          state_nxt_s = LPC_IDLE;
        end
      end
      LPC_SRC, LPC_WB: begin
        if (advance_s && last_s) begin
          state_nxt_s = LPC_IDLE;
        end else begin
          state_nxt_s = state_r;
        end
      end
      default: state_nxt_s = LPC_IDLE;
    endcase
  end

  // State and round-robin history; reset favours src on the first tie
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r      <= LPC_IDLE;
      rr_last_wb_r <= 1'b1;
    end else begin
      state_r <= state_nxt_s;
      if (grant_src_s) begin
        rr_last_wb_r <= 1'b0;
      end else if (grant_wb_s) begin
        rr_last_wb_r <= 1'b1;
      end else begin
        rr_last_wb_r <= rr_last_wb_r;
      end
    end
  end

  // Output decode from the state and rotation registers
  always_comb begin
    O_Sel_Path    = {3'b000, I_Local_Sel};
    O_Sel_Path_WB = SEL_WB_EXEC;
    case (state_r)
      LPC_SRC:  O_Sel_Path    = lane_code(rot_s);
      LPC_WB:   O_Sel_Path_WB = lane_code(rot_s);
      default: begin
        O_Sel_Path    = {3'b000, I_Local_Sel};
        O_Sel_Path_WB = SEL_WB_EXEC;
      end
    endcase
  end

  assign O_Ack_Src    = grant_src_s;
  assign O_Ack_WB     = grant_wb_s;
  assign O_Lane_Req   = (state_r == LPC_SRC);
  assign O_Busy       = (state_r != LPC_IDLE);
  assign O_Beat_Valid = advance_s;
  assign O_Done_Src   = advance_s && last_s && (state_r == LPC_SRC);
  assign O_Done_WB    = advance_s && last_s && (state_r == LPC_WB);

endmodule
